// File: rtl/vdp_sprite_pkg.sv
// rtl/vdp_sprite_pkg.sv - shared types, constants and helpers for the sprite line scanner
// Contents:
//   scan_state_t  scanner FSM states (IDLE/REQ/EVAL/FIN)
//   Y_TERM_M1     attribute Y value that ends the table in sprite mode 1
//   Y_TERM_M2     attribute Y value that ends the table in sprite mode 2
//   sp_height()   sprite height in lines from size/zoom bits (8/16/32)
package vdp_sprite_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_EVAL,
      ST_FIN
   } scan_state_t;

   localparam logic [7:0] Y_TERM_M1 = 8'd208;
   localparam logic [7:0] Y_TERM_M2 = 8'd216;

   function automatic logic [7:0] sp_height(input logic size, input logic zoom);
      case ({size, zoom})
         2'b00:   sp_height = 8'd8;
         2'b01:   sp_height = 8'd16;
         2'b10:   sp_height = 8'd16;
         default: sp_height = 8'd32;
      endcase
   endfunction

endpackage

// File: rtl/vdp_sprite_ymatch.sv
// rtl/vdp_sprite_ymatch.sv - combinational Y-range and terminator test for one attribute entry
// Ports:
//   line_y   in  8  target line
//   y        in  8  attribute Y byte
//   size     in  1  0=8px, 1=16px
//   zoom     in  1  1=magnified x2
//   mode2    in  1  selects the terminator value
//   match    out 1  line falls inside the sprite
//   is_term  out 1  entry is the end-of-table marker
module vdp_sprite_ymatch
   import vdp_sprite_pkg::*;
(
   input  logic [7:0] line_y,
   input  logic [7:0] y,
   input  logic       size,
   input  logic       zoom,
   input  logic       mode2,
   output logic       match,
   output logic       is_term
);

   logic [7:0] diff;

   // 8-bit wrap lets sprites that start near the bottom of the Y range
   // cover the first lines of the next frame.
   assign diff    = line_y - y;
   assign match   = (diff < sp_height(size, zoom));
   assign is_term = (y == (mode2 ? Y_TERM_M2 : Y_TERM_M1));

endmodule

// File: rtl/vdp_sprite_line_scanner.sv
// rtl/vdp_sprite_line_scanner.sv - per-line sprite attribute scanner building the visible sprite list
// Ports:
//   CLK21M, RESET_N              clock, synchronous active-low reset
//   START, LINE_Y                start pulse and target line
//   SPMODE2, REG_R1_SP_SIZE,
//   REG_R1_SP_ZOOM,
//   REG_R11R5_SP_ATR_ADDR        scan configuration, sampled at START
//   VRAM_REQ/ADR/ACK/DAT         attribute Y byte read port
//   BUSY, DONE                   scan status
//   LIST_COUNT, LIST_NUM         visible sprite list (slot k = LIST_NUM[5k+4:5k])
//   OVERMAP, OVERMAP_NUM         sticky overmap status
//   CLR_REQ, CLR_ACK             toggle handshake clearing OVERMAP
module vdp_sprite_line_scanner
   import vdp_sprite_pkg::*;
#(
   parameter int MAX_PER_LINE = 8,
   parameter int NUM_SPRITES  = 32,
   parameter int CNT_W        = $clog2(MAX_PER_LINE + 1)
) (
   input  logic                      CLK21M,
   input  logic                      RESET_N,
   input  logic                      START,
   input  logic [7:0]                LINE_Y,
   input  logic                      SPMODE2,
   input  logic                      REG_R1_SP_SIZE,
   input  logic                      REG_R1_SP_ZOOM,
   input  logic [9:0]                REG_R11R5_SP_ATR_ADDR,
   output logic                      VRAM_REQ,
   output logic [16:0]               VRAM_ADR,
   input  logic                      VRAM_ACK,
   input  logic [7:0]                VRAM_DAT,
   output logic                      BUSY,
   output logic                      DONE,
   output logic [CNT_W-1:0]          LIST_COUNT,
   output logic [5*MAX_PER_LINE-1:0] LIST_NUM,
   output logic                      OVERMAP,
   output logic [4:0]                OVERMAP_NUM,
   input  logic                      CLR_REQ,
   output logic                      CLR_ACK
);

   localparam logic [CNT_W-1:0] LIMIT_M2 = CNT_W'(MAX_PER_LINE);
   localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(MAX_PER_LINE / 2);
   localparam logic [4:0]       LAST_NUM = 5'(NUM_SPRITES - 1);

   scan_state_t state, state_nxt;

   logic [4:0]       num;
   logic [7:0]       line_y_q;
   logic             mode2_q;
   logic             size_q;
   logic             zoom_q;
   logic [9:0]       atr_q;
   logic [7:0]       y_q;
   logic [4:0]       list_num [MAX_PER_LINE];
   logic             restart_gap;

   logic [CNT_W-1:0] limit;
   logic             list_full;
   logic             y_match;
   logic             y_term;
   logic             eval_go;
   logic             ack_taken;
   logic             list_add;
   logic             ovm_event;

   vdp_sprite_ymatch u_ymatch (
      .line_y  (line_y_q),
      .y       (y_q),
      .size    (size_q),
      .zoom    (zoom_q),
      .mode2   (mode2_q),
      .match   (y_match),
      .is_term (y_term)
   );

   assign limit     = mode2_q ? LIMIT_M2 : LIMIT_M1;
   assign list_full = (LIST_COUNT == limit);
   assign VRAM_ADR  = {atr_q, num, 2'b00};

   // A START always wins over the work of the current cycle so an aborted
   // scan never lists, flags or advances anything.
   assign eval_go   = (state == ST_EVAL) && !START;
   assign ack_taken = (state == ST_REQ) && !restart_gap && VRAM_ACK && !START;
   assign list_add  = eval_go && !y_term && y_match && !list_full;
   assign ovm_event = eval_go && !y_term && y_match && list_full;

   always_ff @(posedge CLK21M) begin
      if (!RESET_N) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      VRAM_REQ  = 1'b0;
      BUSY      = 1'b0;
      DONE      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (START) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            BUSY = 1'b1;
            // After an abort the request drops for one cycle so the memory
            // side sees the old transfer end before the new address appears.
            VRAM_REQ = !restart_gap;
            if (START)          state_nxt = ST_REQ;
            else if (ack_taken) state_nxt = ST_EVAL;
         end
         ST_EVAL: begin
            BUSY = 1'b1;
            if (START)                                       state_nxt = ST_REQ;
            else if (y_term || ovm_event || num == LAST_NUM) state_nxt = ST_FIN;
            else                                             state_nxt = ST_REQ;
         end
         ST_FIN: begin
            BUSY      = 1'b1;
            DONE      = 1'b1;
            state_nxt = START ? ST_REQ : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK21M) begin
      if (!RESET_N) begin
         num         <= '0;
         line_y_q    <= '0;
         mode2_q     <= 1'b0;
         size_q      <= 1'b0;
         zoom_q      <= 1'b0;
         atr_q       <= '0;
         y_q         <= '0;
         restart_gap <= 1'b0;
         LIST_COUNT  <= '0;
         OVERMAP     <= 1'b0;
         OVERMAP_NUM <= '0;
         CLR_ACK     <= 1'b0;
         for (int k = 0; k < MAX_PER_LINE; k++) begin
            list_num[k] <= '0;
         end
      end else begin
         if (START) begin
            line_y_q    <= LINE_Y;
            mode2_q     <= SPMODE2;
            size_q      <= REG_R1_SP_SIZE;
            zoom_q      <= REG_R1_SP_ZOOM;
            atr_q       <= REG_R11R5_SP_ATR_ADDR;
            num         <= '0;
            LIST_COUNT  <= '0;
            restart_gap <= (state == ST_REQ);
         end else begin
            restart_gap <= 1'b0;
            if (ack_taken) y_q <= VRAM_DAT;
            if (state == ST_EVAL && state_nxt == ST_REQ) num <= num + 5'd1;
            if (list_add) begin
               for (int k = 0; k < MAX_PER_LINE; k++) begin
                  if (CNT_W'(k) == LIST_COUNT) list_num[k] <= num;
               end
               LIST_COUNT <= LIST_COUNT + 1'b1;
            end
         end

         // Clear first so a same-cycle overmap event overrides it.
         if (CLR_REQ != CLR_ACK) begin
            OVERMAP <= 1'b0;
            CLR_ACK <= CLR_REQ;
         end
         if (ovm_event) OVERMAP <= 1'b1;
         if (eval_go && !OVERMAP) OVERMAP_NUM <= num;
      end
   end

   always_comb begin
      LIST_NUM = '0;
      for (int k = 0; k < MAX_PER_LINE; k++) begin
         LIST_NUM[5*k +: 5] = list_num[k];
      end
   end

endmodule

// File: tb/tb_vdp_sprite_line_scanner.sv
// tb/tb_vdp_sprite_line_scanner.sv - directed self-checking bench for vdp_sprite_line_scanner
module tb_vdp_sprite_line_scanner;

   logic        CLK21M;
   logic        RESET_N;
   logic        START;
   logic [7:0]  LINE_Y;
   logic        SPMODE2;
   logic        REG_R1_SP_SIZE;
   logic        REG_R1_SP_ZOOM;
   logic [9:0]  REG_R11R5_SP_ATR_ADDR;
   logic        VRAM_REQ;
   logic [16:0] VRAM_ADR;
   logic        VRAM_ACK;
   logic [7:0]  VRAM_DAT;
   logic        BUSY;
   logic        DONE;
   logic [3:0]  LIST_COUNT;
   logic [39:0] LIST_NUM;
   logic        OVERMAP;
   logic [4:0]  OVERMAP_NUM;
   logic        CLR_REQ;
   logic        CLR_ACK;

   logic        req16;
   logic [16:0] adr16;
   logic        ack16;
   logic [7:0]  dat16;
   logic        busy16;
   logic        done16;
   logic [4:0]  cnt16;
   logic [79:0] list16;
   logic        ovm16;
   logic [4:0]  ovmn16;
   logic        clrack16;

   logic [7:0]  y_mem [32];
   int          ack_delay_max;
   int          cur_delay;
   int          wait_cnt;
   int          ack_total;
   logic [4:0]  last_rd;
   int          done_cnt;
   int          done16_cnt;
   int          checks;
   int          errors;

   vdp_sprite_line_scanner dut (
      .CLK21M(CLK21M), .RESET_N(RESET_N), .START(START), .LINE_Y(LINE_Y),
      .SPMODE2(SPMODE2), .REG_R1_SP_SIZE(REG_R1_SP_SIZE), .REG_R1_SP_ZOOM(REG_R1_SP_ZOOM),
      .REG_R11R5_SP_ATR_ADDR(REG_R11R5_SP_ATR_ADDR),
      .VRAM_REQ(VRAM_REQ), .VRAM_ADR(VRAM_ADR), .VRAM_ACK(VRAM_ACK), .VRAM_DAT(VRAM_DAT),
      .BUSY(BUSY), .DONE(DONE), .LIST_COUNT(LIST_COUNT), .LIST_NUM(LIST_NUM),
      .OVERMAP(OVERMAP), .OVERMAP_NUM(OVERMAP_NUM), .CLR_REQ(CLR_REQ), .CLR_ACK(CLR_ACK)
   );

   vdp_sprite_line_scanner #(.MAX_PER_LINE(16)) dut16 (
      .CLK21M(CLK21M), .RESET_N(RESET_N), .START(START), .LINE_Y(LINE_Y),
      .SPMODE2(SPMODE2), .REG_R1_SP_SIZE(REG_R1_SP_SIZE), .REG_R1_SP_ZOOM(REG_R1_SP_ZOOM),
      .REG_R11R5_SP_ATR_ADDR(REG_R11R5_SP_ATR_ADDR),
      .VRAM_REQ(req16), .VRAM_ADR(adr16), .VRAM_ACK(ack16), .VRAM_DAT(dat16),
      .BUSY(busy16), .DONE(done16), .LIST_COUNT(cnt16), .LIST_NUM(list16),
      .OVERMAP(ovm16), .OVERMAP_NUM(ovmn16), .CLR_REQ(1'b0), .CLR_ACK(clrack16)
   );

   initial begin
      CLK21M = 1'b0;
      forever #5 CLK21M = ~CLK21M;
   end

   // Attribute memory responder for the main instance, optional random latency.
   initial begin
      VRAM_ACK = 1'b0; VRAM_DAT = '0; wait_cnt = 0; cur_delay = 0;
      ack_total = 0; last_rd = '0;
      forever begin
         @(negedge CLK21M);
         VRAM_ACK = 1'b0;
         if (VRAM_REQ) begin
            if (wait_cnt >= cur_delay) begin
               VRAM_ACK  = 1'b1;
               VRAM_DAT  = y_mem[VRAM_ADR[6:2]];
               last_rd   = VRAM_ADR[6:2];
               ack_total = ack_total + 1;
               wait_cnt  = 0;
               cur_delay = int'($urandom_range(ack_delay_max));
            end else begin
               wait_cnt = wait_cnt + 1;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   initial begin
      ack16 = 1'b0; dat16 = '0;
      forever begin
         @(negedge CLK21M);
         ack16 = req16;
         dat16 = y_mem[adr16[6:2]];
      end
   end

   initial begin
      done_cnt = 0; done16_cnt = 0;
      forever begin
         @(negedge CLK21M);
         if (DONE)   done_cnt   = done_cnt + 1;
         if (done16) done16_cnt = done16_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks = checks + 1;
      assert (obs === exp) else begin
         errors = errors + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge CLK21M);
   endtask

   task automatic start_scan(input logic [7:0] ly, input logic m2, input logic sz, input logic zm);
      @(negedge CLK21M);
      LINE_Y = ly; SPMODE2 = m2; REG_R1_SP_SIZE = sz; REG_R1_SP_ZOOM = zm;
      START = 1'b1;
      @(negedge CLK21M);
      START = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 3000 && !got; i++) begin
         @(negedge CLK21M);
         if (DONE) got = 1'b1;
      end
      chk(tag, got, 1);
   endtask

   task automatic wait_req_num(input string tag, input logic [4:0] n);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
         @(negedge CLK21M);
         if (VRAM_REQ && VRAM_ADR[6:2] == n) got = 1'b1;
      end
      chk(tag, got, 1);
   endtask

   task automatic toggle_clr();
      @(negedge CLK21M);
      CLR_REQ = ~CLR_REQ;
      tick(2);
   endtask

   initial begin
      logic [39:0] exp8;
      logic [39:0] exp_r;
      logic [79:0] exp16;
      int          d0;
      int          d16;
      int          a0;
      logic        got;

      checks = 0; errors = 0; ack_delay_max = 0;
      RESET_N = 1'b0; START = 1'b0; LINE_Y = '0; SPMODE2 = 1'b0;
      REG_R1_SP_SIZE = 1'b0; REG_R1_SP_ZOOM = 1'b0; REG_R11R5_SP_ATR_ADDR = 10'h155;
      CLR_REQ = 1'b0;
      for (int i = 0; i < 32; i++) y_mem[i] = 8'd97;
      for (int k = 0; k < 8; k++)  exp8[5*k +: 5] = 5'(k);
      for (int k = 0; k < 8; k++)  exp_r[5*k +: 5] = 5'(k + 1);
      for (int k = 0; k < 16; k++) exp16[5*k +: 5] = 5'(k);

      tick(3);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_req", VRAM_REQ, 0);
      chk("rst_adr", VRAM_ADR, 0);
      chk("rst_count", LIST_COUNT, 0);
      chk("rst_list", LIST_NUM, 0);
      chk("rst_ovm", OVERMAP, 0);
      chk("rst_ovm_num", OVERMAP_NUM, 0);
      chk("rst_clr_ack", CLR_ACK, 0);
      RESET_N = 1'b1;
      tick(2);

      // Mode 2, every entry covers line 100: 8 listed, ninth overflows.
      d0 = done_cnt; d16 = done16_cnt;
      start_scan(8'd100, 1'b1, 1'b0, 1'b0);
      chk("t1_req", VRAM_REQ, 1);
      chk("t1_adr", VRAM_ADR, {10'h155, 7'd0});
      chk("t1_busy", BUSY, 1);
      wait_done("t1_done_seen");
      chk("t1_count", LIST_COUNT, 8);
      chk("t1_list", LIST_NUM, exp8);
      chk("t1_ovm", OVERMAP, 1);
      chk("t1_ovm_num", OVERMAP_NUM, 8);
      got = 1'b0;
      for (int i = 0; i < 500 && !got; i++) begin
         @(negedge CLK21M);
         if (done16_cnt != d16) got = 1'b1;
      end
      chk("t1_16_done_seen", got, 1);
      chk("t1_16_count", cnt16, 16);
      chk("t1_16_list", list16, exp16);
      chk("t1_16_ovm", ovm16, 1);
      chk("t1_16_ovm_num", ovmn16, 16);
      tick(3);
      chk("t1_16_busy", busy16, 0);
      chk("t1_16_clr_ack", clrack16, 0);
      chk("t1_done_once", done_cnt - d0, 1);
      chk("t1_idle", BUSY, 0);
      toggle_clr();
      chk("clr1_ovm", OVERMAP, 0);
      chk("clr1_ack", CLR_ACK, 1);
      chk("clr1_ovm_num", OVERMAP_NUM, 8);

      // Mode 1 limit is 4.
      start_scan(8'd100, 1'b0, 1'b0, 1'b0);
      wait_done("t2_done_seen");
      chk("t2_count", LIST_COUNT, 4);
      chk("t2_list", LIST_NUM[19:0], exp8[19:0]);
      chk("t2_ovm", OVERMAP, 1);
      chk("t2_ovm_num", OVERMAP_NUM, 4);
      toggle_clr();
      chk("clr2_ovm", OVERMAP, 0);
      chk("clr2_ack", CLR_ACK, 0);

      // Mode 1 terminator at sprite 2; sprite 3 must never be read.
      y_mem[2] = 8'd208;
      a0 = ack_total;
      start_scan(8'd100, 1'b0, 1'b0, 1'b0);
      wait_done("t3_done_seen");
      chk("t3_count", LIST_COUNT, 2);
      chk("t3_ovm", OVERMAP, 0);
      chk("t3_ovm_num", OVERMAP_NUM, 2);
      chk("t3_last_rd", last_rd, 2);
      chk("t3_reads", ack_total - a0, 3);

      // Mode 2 terminator at sprite 1; 208 is an ordinary Y in mode 2.
      y_mem[1] = 8'd216;
      start_scan(8'd100, 1'b1, 1'b0, 1'b0);
      wait_done("t3b_done_seen");
      chk("t3b_count", LIST_COUNT, 1);
      chk("t3b_slot0", LIST_NUM[4:0], 0);
      chk("t3b_ovm_num", OVERMAP_NUM, 1);

      // Y wrap: line 5 vs Y=250 (diff 11) and Y=245 (diff 16).
      y_mem[0] = 8'd250; y_mem[1] = 8'd245; y_mem[2] = 8'd216;
      start_scan(8'd5, 1'b1, 1'b1, 1'b0);
      wait_done("t4_done_seen");
      chk("t4_h16_count", LIST_COUNT, 1);
      chk("t4_h16_slot0", LIST_NUM[4:0], 0);
      chk("t4_h16_ovm_num", OVERMAP_NUM, 2);
      start_scan(8'd5, 1'b1, 1'b1, 1'b1);
      wait_done("t4_h32_done_seen");
      chk("t4_h32_count", LIST_COUNT, 2);
      chk("t4_h32_slots", LIST_NUM[9:0], {5'd1, 5'd0});
      start_scan(8'd5, 1'b1, 1'b0, 1'b0);
      wait_done("t4_h8_done_seen");
      chk("t4_h8_count", LIST_COUNT, 0);

      // No match and no terminator: full walk to the last entry.
      for (int i = 0; i < 32; i++) y_mem[i] = 8'd192;
      a0 = ack_total;
      start_scan(8'd100, 1'b1, 1'b0, 1'b0);
      wait_done("walk_done_seen");
      chk("walk_count", LIST_COUNT, 0);
      chk("walk_ovm", OVERMAP, 0);
      chk("walk_ovm_num", OVERMAP_NUM, 31);
      chk("walk_last_rd", last_rd, 31);
      chk("walk_reads", ack_total - a0, 32);

      // Clear request lands in the overmap-event cycle: set wins, ACK toggles.
      for (int i = 0; i < 32; i++) y_mem[i] = 8'd97;
      start_scan(8'd100, 1'b1, 1'b0, 1'b0);
      wait_req_num("t5_req8", 5'd8);
      got = 1'b0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge CLK21M);
         if (!VRAM_REQ) got = 1'b1;
      end
      chk("t5_eval_seen", got, 1);
      CLR_REQ = 1'b1;
      @(negedge CLK21M);
      chk("t5_ovm_set_wins", OVERMAP, 1);
      chk("t5_ack_toggled", CLR_ACK, 1);
      chk("t5_ovm_num", OVERMAP_NUM, 8);
      chk("t5_done", DONE, 1);
      toggle_clr();
      chk("t5_ovm_cleared", OVERMAP, 0);
      chk("t5_ack2", CLR_ACK, 0);
      chk("t5_ovm_num_hold", OVERMAP_NUM, 8);
      toggle_clr();
      chk("t6_pre_ack", CLR_ACK, 1);

      // Abort mid-request with random latency, restart on a new line.
      ack_delay_max = 3;
      y_mem[0] = 8'd0;
      d0 = done_cnt;
      start_scan(8'd100, 1'b1, 1'b0, 1'b0);
      wait_req_num("t6_req3", 5'd3);
      LINE_Y = 8'd5;
      START = 1'b1;
      @(negedge CLK21M);
      START = 1'b0;
      chk("t6_gap", VRAM_REQ, 0);
      @(negedge CLK21M);
      chk("t6_rereq", VRAM_REQ, 1);
      chk("t6_readr", VRAM_ADR, {10'h155, 7'd0});
      wait_done("t6_done_seen");
      chk("t6_count", LIST_COUNT, 1);
      chk("t6_slot0", LIST_NUM[4:0], 0);
      chk("t6_ovm", OVERMAP, 0);
      chk("t6_ovm_num", OVERMAP_NUM, 31);
      tick(3);
      chk("t6_done_once", done_cnt - d0, 1);

      // Reset in the middle of a scan.
      start_scan(8'd100, 1'b1, 1'b0, 1'b0);
      wait_req_num("rs_req2", 5'd2);
      RESET_N = 1'b0;
      @(negedge CLK21M);
      chk("rs_busy", BUSY, 0);
      chk("rs_req", VRAM_REQ, 0);
      chk("rs_adr", VRAM_ADR, 0);
      chk("rs_done", DONE, 0);
      chk("rs_count", LIST_COUNT, 0);
      chk("rs_list", LIST_NUM, 0);
      chk("rs_ovm", OVERMAP, 0);
      chk("rs_ovm_num", OVERMAP_NUM, 0);
      chk("rs_clr_ack", CLR_ACK, 0);
      RESET_N = 1'b1;
      ack_delay_max = 0;
      start_scan(8'd100, 1'b1, 1'b0, 1'b0);
      chk("rs_restart_adr", VRAM_ADR, {10'h155, 7'd0});
      wait_done("rs_done_seen");
      chk("rs_scan_count", LIST_COUNT, 8);
      chk("rs_scan_list", LIST_NUM, exp_r);
      chk("rs_scan_ovm", OVERMAP, 1);
      chk("rs_scan_ovm_num", OVERMAP_NUM, 9);
      chk("rs_scan_clr_ack", CLR_ACK, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
